seg7_scan_display: RTL and testbench
====================================

# seg7_scan_display

Parametrised, time-multiplexed 7-segment display driver for the FPGA board top levels. It scans `NUM_DIGITS` common-anode digits from a packed hex value, with per-digit decimal points, per-digit blanking, optional leading-zero suppression and tear-free value updates. It sits between the user project outputs and the board `seg`/`dp`/`an` pins, and replaces the fixed single-digit `an = 1110` wiring.

## Interface

Parameters:

- `NUM_DIGITS`, 4: number of digits scanned, 1..8.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit, at least 2.
- `ACTIVE_LOW`, 1: 1 means `seg`, `dp` and `an` are driven active-low; 0 means active-high.

Ports:

- `clk` in, 1: system clock.
- `rst_n` in, 1: reset. One clock; reset is asynchronous and active-low.
- `en` in, 1: display enable.
- `value` in, 4*NUM_DIGITS: hex nibbles; digit i is `value[4i+3:4i]`, and digit 0 is rightmost.
- `dp_in` in, NUM_DIGITS: decimal point request per digit, 1 = lit.
- `blank` in, NUM_DIGITS: force digit dark, 1 = dark.
- `lz_en` in, 1: leading-zero suppression enable.
- `load` in, 1: capture `value`, `dp_in` and `blank` into the pending register.
- `seg` out, 7: segments; bit 0 = a … bit 6 = g.
- `dp` out, 1: decimal point.
- `an` out, NUM_DIGITS: digit anodes, one-hot when lit.
- `frame_start` out, 1: one-cycle pulse when digit 0 becomes lit.

## Operation

- **Registers.**
  - Prescaler `pre`, range 0..REFRESH_DIV-1.
  - Digit index `idx`, range 0..NUM_DIGITS-1.
  - `pending` and `active` copies of {value, dp_in, blank}.
  - Registered outputs.
- **Tick.** A tick is `pre == REFRESH_DIV-1`. On a tick, `pre` goes to 0 and `idx` advances. From NUM_DIGITS-1 it wraps to 0.
- **Load.** When `load` is high in a cycle, `pending` captures the inputs. The last load before a transfer wins.
- **Transfer (tear-free).** `active` takes `pending` only on the tick where `idx` wraps to 0. A whole frame therefore always shows one snapshot. With NUM_DIGITS=1, the transfer happens on every tick.
- **Decode.** Decoding uses the active-high table below. The output is inverted when ACTIVE_LOW=1.
  - Digits 0–7: 3F, 06, 5B, 4F, 66, 6D, 7D, 07.
  - Digits 8–F: 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- **Leading-zero suppression.** When `lz_en` = 1, digit i is suppressed if every active nibble from i up to NUM_DIGITS-1 is 0. Digit 0 is never suppressed.
  - Suppression and `blank` both turn off the segments and dp. The anode is still driven.
  - `lz_en` is sampled live, not snapshotted.
- **Disabled state.** When `en` = 0:
  - `pre` and `idx` are held at 0.
  - `active` takes `pending` every cycle.
  - All outputs are off and `frame_start` is 0.
- **Output off levels.**
  - ACTIVE_LOW=1: seg = 7'h7F, dp = 1, an = all 1.
  - ACTIVE_LOW=0: all 0.

## Timing

- **Output register.** Outputs are registered and reflect `idx`/`active` one cycle late. `an`, `seg` and `dp` change on the same edge, so there is no partial-digit glitch.
- **Dwell.** Each digit is lit for exactly REFRESH_DIV cycles. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- **frame_start.** It pulses on the same edge at which `an` selects digit 0 (idx 0 output).
- **Reset values** while `rst_n` is low:
  - All outputs are at their off level and `frame_start` = 0.
  - `pre` = 0, `idx` = 0.
  - `pending` and `active` are all zero.
- **Reset exit.** On the first edge after `rst_n` rises with `en` = 1, digit 0 is lit and `frame_start` pulses. The first tick follows REFRESH_DIV-1 edges later.
- **Reset mid-scan.** Asserting reset mid-scan blanks outputs immediately, without waiting for a clock edge.
- **Enable changes.**
  - `en` falling: outputs are off on the next edge.
  - `en` rising: behaves exactly like reset exit, with the loaded value shown at once.
- **Load on a wrap tick.** If `load` and the wrap tick occur in the same cycle, `active` gets the old `pending`. The new value waits one frame.

## Test plan

All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.

1. **Reset.** Hold reset for 3 cycles. Require seg=7F, dp=1, an=F, frame_start=0. Release with en=1 and pre-reset load 16'h0000; the first edge gives an=E, seg=40.
2. **Scan.** Load 16'h12AF with dp_in=0010, then let `en` rise. Require:
   - an=E, seg=0E for 4 cycles;
   - then an=D, seg=08, dp=0;
   - then an=B, seg=24;
   - then an=7, seg=79;
   - then wrap to an=E with frame_start=1.
3. **Tear-free update.** Load 16'h3333 mid-frame, while digit 1 is lit. Require digits 2–3 still show 12AF, and all digits show 3 (seg=30) from the next frame.
4. **Leading-zero suppression.** With lz_en=1:
   - value 16'h0050: digits 3 and 2 are dark (seg=7F, an still cycles), digit 1 seg=12, digit 0 seg=40;
   - value 16'h0000: only digit 0 is lit with seg=40.
5. **Blank and enable.** blank=0001 darkens digit 0 only. Drop `en` mid-scan: require an=F on the next edge. Raise `en`: require an=E on the following edge.
6. **Async reset mid-frame.** Pull rst_n low between clock edges. Require outputs to go to the off level before the next edge.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode 7-segment driver: scans NUM_DIGITS hex digits with
// per-digit dp/blank, leading-zero suppression and frame-aligned (tear-free) updates.
module seg7_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] val;
        logic [NUM_DIGITS-1:0]   dpt;
        logic [NUM_DIGITS-1:0]   blk;
    } snap_t;

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;
    snap_t            pending;
    snap_t            active;
    snap_t            incoming;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  suppress;
    logic                  zero_run;
    logic                  dark;
    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] an_on;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign incoming = '{val: value, dpt: dp_in, blk: blank};
    assign tick     = (pre == PRE_LAST);
    assign wrap     = tick && (idx == IDX_LAST);

    // Walk from the most significant digit down so zero_run tells whether every
    // nibble from the selected digit upward is zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        suppress  = 1'b0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active.val[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                nib       = active.val[4*i +: 4];
                cur_dp    = active.dpt[i];
                cur_blank = active.blk[i];
                suppress  = lz_en && (i != 0) && zero_run;
            end
        end
    end

    assign dark   = cur_blank || suppress;
    assign seg_on = dark ? 7'h00 : decode(nib);
    assign dp_on  = cur_dp && !dark;
    assign an_on  = NUM_DIGITS'(1) << idx;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the snapshot registers are reset too, so a frame shown right after
        // reset is a defined all-zero value rather than power-up garbage.
        if (!rst_n) begin
            pre         <= '0;
            idx         <= '0;
            pending     <= '0;
            active      <= '0;
            seg         <= SEG_OFF;
            dp          <= ACTIVE_LOW;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let active take the pre-load pending
            // value when load and the wrap tick coincide.
            if (load) begin
                pending <= incoming;
            end
            if (!en) begin
                pre         <= '0;
                idx         <= '0;
                active      <= pending;
                seg         <= SEG_OFF;
                dp          <= ACTIVE_LOW;
                an          <= AN_OFF;
                frame_start <= 1'b0;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) begin
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
                if (wrap) begin
                    active <= pending;
                end
                seg         <= seg_on ^ SEG_OFF;
                dp          <= dp_on ^ ACTIVE_LOW;
                an          <= an_on ^ AN_OFF;
                frame_start <= (idx == '0) && (pre == '0);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: directed scenarios plus random traffic,
// compared against a frame/cycle-count reference model.
module tb_seg7_scan_display;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int FR = N * R;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        lz_en = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    always #5 clk = ~clk;

    seg7_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in), .blank(blank),
        .lz_en(lz_en), .load(load), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: the snapshot being shown, the one waiting, and the number
    // of enabled edges since the scan (re)started.
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_ad, m_pb, m_ab;
    int          m_pos;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fs;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_off();
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
    endtask

    task automatic reset_model();
        m_pv = '0; m_av = '0; m_pd = '0; m_ad = '0; m_pb = '0; m_ab = '0; m_pos = 0;
        expect_off();
    endtask

    task automatic model_edge();
        int         d;
        logic [3:0] nib;
        logic       dark;
        if (!rst_n) begin
            reset_model();
            return;
        end
        if (!en) begin
            expect_off();
            m_av = m_pv; m_ad = m_pd; m_ab = m_pb;
            m_pos = 0;
        end else begin
            d     = (m_pos / R) % N;
            nib   = m_av[4*d +: 4];
            dark  = m_ab[d] || (lz_en && d != 0 && (m_av >> (4*d)) == 16'h0);
            e_an  = ~(4'b0001 << d);
            e_seg = dark ? 7'h7F : ~seg_tab[nib];
            e_dp  = ~(m_ad[d] && !dark);
            e_fs  = (m_pos % FR) == 0;
            if (m_pos % FR == FR - 1) begin
                m_av = m_pv; m_ad = m_pd; m_ab = m_pb;
            end
            m_pos++;
        end
        if (load) begin
            m_pv = value; m_pd = dp_in; m_pb = blank;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, {an, seg, dp, frame_start}, {e_an, e_seg, e_dp, e_fs});
    endtask

    task automatic check_seg(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        check(tag, {1'b0, an, seg}, {1'b0, exp_an, exp_seg});
    endtask

    // Stop, load a new snapshot and restart the scan so digit 0 comes up next edge.
    task automatic restart_with(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        en = 1'b0; value = v; dp_in = d; blank = b; load = 1'b1;
        step("restart_load");
        load = 1'b0;
        step("restart_idle");
        en = 1'b1;
    endtask

    logic [3:0] scan_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] scan_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic [6:0] lz_seg   [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};

    initial begin
        reset_model();

        // Reset held for three edges, then released with en high.
        en = 1'b1; value = 16'h0000; load = 1'b1;
        for (int i = 0; i < 3; i++) step("reset_hold");
        check("reset_levels", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        #2 rst_n = 1'b1; load = 1'b0;
        step("reset_exit");
        check_seg("reset_exit_lit", 4'hE, 7'h40);
        check("reset_exit_fs", {11'b0, frame_start}, 12'h001);
        for (int i = 0; i < 8; i++) step("post_reset");

        // Scan of 12AF with a decimal point on digit 1.
        restart_with(16'h12AF, 4'b0010, 4'b0000);
        for (int dg = 0; dg < 4; dg++) begin
            for (int c = 0; c < R; c++) begin
                step("scan");
                check_seg("scan_digit", scan_an[dg], scan_seg[dg]);
                check("scan_dp", {11'b0, dp}, {11'b0, (dg != 1)});
            end
        end
        step("scan_wrap");
        check("scan_wrap_fs", {7'b0, an, frame_start}, {7'b0, 4'hE, 1'b1});

        // Tear-free update: load 3333 while digit 1 is lit.
        for (int i = 0; i < 3; i++) step("tear_d0");
        step("tear_d1");
        value = 16'h3333; load = 1'b1;
        step("tear_load");
        load = 1'b0;
        for (int i = 0; i < 2; i++) step("tear_d1_rest");
        for (int dg = 2; dg < 4; dg++) begin
            for (int c = 0; c < R; c++) begin
                step("tear_old");
                check_seg("tear_old_frame", scan_an[dg], scan_seg[dg]);
            end
        end
        for (int dg = 0; dg < 4; dg++) begin
            for (int c = 0; c < R; c++) begin
                step("tear_new");
                check_seg("tear_new_frame", scan_an[dg], 7'h30);
            end
        end

        // Leading-zero suppression.
        lz_en = 1'b1;
        restart_with(16'h0050, 4'b0000, 4'b0000);
        for (int dg = 0; dg < 4; dg++) begin
            for (int c = 0; c < R; c++) begin
                step("lz_0050");
                check_seg("lz_0050_digit", scan_an[dg], lz_seg[dg]);
            end
        end
        restart_with(16'h0000, 4'b1111, 4'b0000);
        for (int dg = 0; dg < 4; dg++) begin
            for (int c = 0; c < R; c++) begin
                step("lz_0000");
                check_seg("lz_0000_digit", scan_an[dg], (dg == 0) ? 7'h40 : 7'h7F);
                check("lz_0000_dp", {11'b0, dp}, {11'b0, (dg != 0)});
            end
        end

        // Blank digit 0, then drop and raise en mid-scan.
        lz_en = 1'b0;
        restart_with(16'h1234, 4'b0000, 4'b0001);
        for (int c = 0; c < R; c++) begin
            step("blank_d0");
            check_seg("blank_d0_dark", 4'hE, 7'h7F);
        end
        for (int c = 0; c < R; c++) begin
            step("blank_d1");
            check_seg("blank_d1_lit", 4'hD, 7'h30);
        end
        step("blank_d2");
        en = 1'b0;
        step("en_fall");
        check("en_fall_off", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        en = 1'b1;
        step("en_rise");
        check("en_rise_d0", {7'b0, an, frame_start}, {7'b0, 4'hE, 1'b1});

        // Asynchronous reset between edges.
        for (int i = 0; i < 5; i++) step("pre_async");
        #3 rst_n = 1'b0;
        #1;
        reset_model();
        check("async_reset_off", {an, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        step("async_hold");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step("async_exit");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            load  = ($urandom_range(3) == 0);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(15) == 0) lz_en = ~lz_en;
            if ($urandom_range(7) == 0) value = value & 16'h00FF;
            if ($urandom_range(7) == 0) value = 16'h0000;
            if (en && $urandom_range(49) == 0) en = 1'b0;
            else if (!en && $urandom_range(2) == 0) en = 1'b1;
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
